// File: rtl/hash_probe_table.sv
// Hashed key/value table with linear probing, one slot examined per clock.
// Optional lookup hit/miss counters are enabled by defining HASH_PROBE_STATS_EN.
module hash_probe_table #(
  parameter int INDEX_BITS = 2,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_op,
  input  logic [31:0]           req_key,
  input  logic [DATA_W-1:0]     req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_hit,
  output logic                  rsp_full,
  output logic [DATA_W-1:0]     rsp_data,
  output logic [INDEX_BITS:0]   rsp_probes
`ifdef HASH_PROBE_STATS_EN
  ,
  output logic [15:0]           stat_hits,
  output logic [15:0]           stat_misses
`endif
);

  localparam int DEPTH  = 1 << INDEX_BITS;
  localparam int NCHUNK = (16 + INDEX_BITS - 1) / INDEX_BITS;
  localparam int PADW   = NCHUNK * INDEX_BITS;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PROBE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  // Fold the 16-bit key fold into INDEX_BITS-wide chunks, zero-padded on top.
  function automatic logic [INDEX_BITS-1:0] f_hash(input logic [31:0] key);
    logic [PADW-1:0]       fp;
    logic [INDEX_BITS-1:0] h;
    fp = PADW'(key[31:16] ^ key[15:0]);
    h  = '0;
    for (int c = 0; c < NCHUNK; c++) h ^= fp[c*INDEX_BITS +: INDEX_BITS];
    return h;
  endfunction

  logic [1:0]             r_state;
  logic [DEPTH-1:0]       r_vld;
  logic [31:0]            r_mkey  [DEPTH];
  logic [DATA_W-1:0]      r_mdata [DEPTH];
  logic                   r_op;
  logic [31:0]            r_key;
  logic [DATA_W-1:0]      r_wdata;
  logic [INDEX_BITS-1:0]  r_ptr;
  logic [INDEX_BITS:0]    r_cnt;
  logic                   r_rsp_valid;
  logic                   r_rsp_hit;
  logic                   r_rsp_full;
  logic [DATA_W-1:0]      r_rsp_data;
  logic [INDEX_BITS:0]    r_rsp_probes;
  logic [15:0]            r_hits;
  logic [15:0]            r_misses;

  logic w_match, w_empty, w_last, w_rsp_take;

  assign w_match    = r_vld[r_ptr] && (r_mkey[r_ptr] == r_key);
  assign w_empty    = !r_vld[r_ptr];
  assign w_last     = (r_cnt == (INDEX_BITS+1)'(DEPTH));
  assign w_rsp_take = (r_state == S_RESP) && r_rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_vld        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mkey[i]  <= '0;
        r_mdata[i] <= '0;
      end
      r_op         <= 1'b0;
      r_key        <= '0;
      r_wdata      <= '0;
      r_ptr        <= '0;
      r_cnt        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_hit    <= 1'b0;
      r_rsp_full   <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_probes <= '0;
      r_hits       <= '0;
      r_misses     <= '0;
    end else if (flush) begin
      r_state      <= S_IDLE;
      r_vld        <= '0;
      r_rsp_valid  <= 1'b0;
      r_hits       <= '0;
      r_misses     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op    <= req_op;
            r_key   <= req_key;
            r_wdata <= req_data;
            r_ptr   <= f_hash(req_key);
            r_cnt   <= (INDEX_BITS+1)'(1);
            r_state <= S_PROBE;
          end
        end
        S_PROBE: begin
          if (w_match || w_empty || w_last) begin
            r_rsp_hit    <= w_match;
            r_rsp_full   <= r_op && !w_match && !w_empty;
            r_rsp_data   <= (!r_op && w_match) ? r_mdata[r_ptr] : '0;
            r_rsp_probes <= r_cnt;
            r_state      <= S_RESP;
            if (r_op && (w_match || w_empty)) begin
              r_vld[r_ptr]   <= 1'b1;
              r_mkey[r_ptr]  <= r_key;
              r_mdata[r_ptr] <= r_wdata;
            end
          end else begin
            r_ptr <= r_ptr + 1'b1;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          // rsp_valid rises one edge after the slot decision, then holds until taken.
          if (!r_rsp_valid) begin
            r_rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
          if (w_rsp_take && !r_op) begin
            if (r_rsp_hit && r_hits != 16'hFFFF)    r_hits   <= r_hits + 16'd1;
            if (!r_rsp_hit && r_misses != 16'hFFFF) r_misses <= r_misses + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign rsp_valid  = r_rsp_valid;
  assign rsp_hit    = r_rsp_hit;
  assign rsp_full   = r_rsp_full;
  assign rsp_data   = r_rsp_data;
  assign rsp_probes = r_rsp_probes;

`ifdef HASH_PROBE_STATS_EN
  assign stat_hits   = r_hits;
  assign stat_misses = r_misses;
`endif

endmodule

// File: tb/tb_hash_probe_table.sv
// Randomized and directed bench for hash_probe_table against an array-based probing model.
module tb_hash_probe_table;
  localparam int IB    = 2;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << IB;

  logic clk = 0, rst_n = 0, flush = 0, req_valid = 0, req_op = 0, rsp_ready = 0;
  logic [31:0] req_key = 0;
  logic [DW-1:0] req_data = 0;
  logic req_ready, rsp_valid, rsp_hit, rsp_full;
  logic [DW-1:0] rsp_data;
  logic [IB:0] rsp_probes;
`ifdef HASH_PROBE_STATS_EN
  logic [15:0] stat_hits, stat_misses;
`endif

  always #5 clk = ~clk;

  hash_probe_table #(.INDEX_BITS(IB), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_key(req_key), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .rsp_full(rsp_full), .rsp_data(rsp_data), .rsp_probes(rsp_probes)
`ifdef HASH_PROBE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  int checks = 0, errors = 0;

  logic [31:0]   m_key  [DEPTH];
  logic [DW-1:0] m_data [DEPTH];
  bit            m_vld  [DEPTH];
  int            m_hits = 0, m_miss = 0;

  logic          g_hit, g_full;
  logic [DW-1:0] g_data;
  logic [IB:0]   g_probes;
  int            g_lat;
  bit            g_to;

  logic          e_hit, e_full;
  logic [DW-1:0] e_data;
  logic [IB:0]   e_probes;

  typedef struct {
    bit op; logic [31:0] k; logic [31:0] d;
    bit hit; bit full; logic [31:0] rd; int pr;
  } vec_t;

  function automatic int m_hash(input logic [31:0] k);
    int f, h;
    f = int'(k[31:16] ^ k[15:0]);
    h = 0;
    while (f != 0) begin
      h = h ^ (f % DEPTH);
      f = f / DEPTH;
    end
    return h;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_vld[i] = 0;
    m_hits = 0;
    m_miss = 0;
  endtask

  task automatic model_op(input bit op, input logic [31:0] k, input logic [DW-1:0] d);
    int s;
    bit done;
    done = 0;
    e_hit = 0; e_full = 0; e_data = '0; e_probes = (IB+1)'(DEPTH);
    for (int n = 0; n < DEPTH; n++) begin
      s = (m_hash(k) + n) % DEPTH;
      if (!done && m_vld[s] && m_key[s] == k) begin
        done = 1; e_hit = 1; e_probes = (IB+1)'(n + 1);
        if (op) m_data[s] = d; else e_data = m_data[s];
      end else if (!done && !m_vld[s]) begin
        done = 1; e_probes = (IB+1)'(n + 1);
        if (op) begin m_vld[s] = 1; m_key[s] = k; m_data[s] = d; end
      end
    end
    if (!done) e_full = op;
    if (!op) begin
      if (e_hit) m_hits++; else m_miss++;
    end
  endtask

  task automatic send_req(input bit op, input logic [31:0] k, input logic [DW-1:0] d);
    @(negedge clk);
    req_op = op; req_key = k; req_data = d; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic wait_rsp();
    g_lat = 0;
    while (rsp_valid !== 1'b1 && g_lat < 3*DEPTH + 8) begin
      @(posedge clk); #1;
      g_lat++;
    end
    g_to = (rsp_valid !== 1'b1);
    g_hit = rsp_hit; g_full = rsp_full; g_data = rsp_data; g_probes = rsp_probes;
  endtask

  task automatic take_rsp(input int delay);
    repeat (delay) @(posedge clk);
    @(negedge clk);
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    model_clear();
  endtask

  task automatic test_reset();
    rst_n = 0;
    #12;
    checks++;
    if ({req_ready, rsp_valid, rsp_hit, rsp_full} !== 4'b1000 || rsp_data !== '0 || rsp_probes !== '0) begin
      errors++;
      $display("FAIL reset: got ready=%0b valid=%0b hit=%0b full=%0b data=%0h probes=%0d exp 1 0 0 0 0 0",
               req_ready, rsp_valid, rsp_hit, rsp_full, rsp_data, rsp_probes);
    end
    @(negedge clk);
    rst_n = 1;
    model_clear();
  endtask

  task automatic test_directed();
    vec_t dv[12];
    dv[0]  = '{0, 32'h5,        0,     0, 0, 0,     1};
    dv[1]  = '{1, 32'h5,        32'hA, 0, 0, 0,     1};
    dv[2]  = '{0, 32'h5,        0,     1, 0, 32'hA, 1};
    dv[3]  = '{1, 32'h5,        32'hC, 1, 0, 0,     1};
    dv[4]  = '{0, 32'h5,        0,     1, 0, 32'hC, 1};
    dv[5]  = '{1, 32'h00010004, 32'hB, 0, 0, 0,     2};
    dv[6]  = '{0, 32'h00010004, 0,     1, 0, 32'hB, 2};
    dv[7]  = '{1, 32'h2,        32'h22,0, 0, 0,     1};
    dv[8]  = '{1, 32'h3,        32'h33,0, 0, 0,     1};
    dv[9]  = '{1, 32'h7,        32'h77,0, 1, 0,     4};
    dv[10] = '{0, 32'h7,        0,     0, 0, 0,     4};
    dv[11] = '{0, 32'h3,        0,     1, 0, 32'h33,1};
    for (int i = 0; i < 12; i++) begin
      send_req(dv[i].op, dv[i].k, dv[i].d);
      wait_rsp();
      take_rsp(0);
      model_op(dv[i].op, dv[i].k, dv[i].d);
      checks++;
      if (g_to || g_hit !== dv[i].hit || g_full !== dv[i].full || g_data !== dv[i].rd ||
          g_probes !== (IB+1)'(dv[i].pr)) begin
        errors++;
        $display("FAIL dir[%0d]: got to=%0b hit=%0b full=%0b data=%0h probes=%0d exp hit=%0b full=%0b data=%0h probes=%0d",
                 i, g_to, g_hit, g_full, g_data, g_probes, dv[i].hit, dv[i].full, dv[i].rd, dv[i].pr);
      end
      checks++;
      if (g_lat !== dv[i].pr + 1) begin
        errors++;
        $display("FAIL dir_latency[%0d]: got %0d exp %0d", i, g_lat, dv[i].pr + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW+IB+3:0] snap;
    bit bad;
    send_req(0, 32'h5, 0);
    wait_rsp();
    model_op(0, 32'h5, 0);
    checks++;
    if (g_to || g_hit !== e_hit || g_data !== e_data || g_probes !== e_probes) begin
      errors++;
      $display("FAIL bp_first: got hit=%0b data=%0h probes=%0d exp hit=%0b data=%0h probes=%0d",
               g_hit, g_data, g_probes, e_hit, e_data, e_probes);
    end
    snap = {rsp_valid, rsp_hit, rsp_full, rsp_data, rsp_probes};
    @(negedge clk);
    req_op = 0; req_key = 32'h3; req_data = 0; req_valid = 1;
    bad = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if ({rsp_valid, rsp_hit, rsp_full, rsp_data, rsp_probes} !== snap || req_ready !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bp_hold: got valid=%0b data=%0h ready=%0b exp held valid=1 data=%0h ready=0",
               rsp_valid, rsp_data, req_ready, e_data);
    end
    @(negedge clk);
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got valid=%0b ready=%0b exp valid=0 ready=1", rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 0;
    wait_rsp();
    take_rsp(0);
    model_op(0, 32'h3, 0);
    checks++;
    if (g_to || g_hit !== e_hit || g_data !== e_data || g_probes !== e_probes || g_lat !== 2) begin
      errors++;
      $display("FAIL bp_second: got hit=%0b data=%0h probes=%0d lat=%0d exp hit=%0b data=%0h probes=%0d lat=2",
               g_hit, g_data, g_probes, g_lat, e_hit, e_data, e_probes);
    end
  endtask

  task automatic test_flush();
    bit seen;
    do_flush();
    send_req(1, 32'h5, 32'h1);         wait_rsp(); take_rsp(0); model_op(1, 32'h5, 32'h1);
    send_req(1, 32'h00010004, 32'h2);  wait_rsp(); take_rsp(0); model_op(1, 32'h00010004, 32'h2);
    checks++;
    if (g_to || g_probes !== 2 || g_hit !== 1'b0) begin
      errors++;
      $display("FAIL flush_setup: got probes=%0d hit=%0b exp probes=2 hit=0", g_probes, g_hit);
    end
    // 0x00030006 homes to slot 0 and would need three probes.
    send_req(1, 32'h00030006, 32'h3);
    do_flush();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_abort: got ready=%0b valid=%0b exp ready=1 valid=0", req_ready, rsp_valid);
    end
    seen = 0;
    repeat (6) begin @(posedge clk); #1; if (rsp_valid !== 1'b0) seen = 1; end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL flush_no_rsp: got rsp_valid=1 exp 0");
    end
`ifdef HASH_PROBE_STATS_EN
    checks++;
    if (stat_hits !== 16'd0 || stat_misses !== 16'd0) begin
      errors++;
      $display("FAIL flush_stats: got hits=%0d misses=%0d exp 0 0", stat_hits, stat_misses);
    end
`endif
    send_req(0, 32'h5, 0); wait_rsp(); take_rsp(0); model_op(0, 32'h5, 0);
    checks++;
    if (g_to || g_hit !== 1'b0 || g_probes !== 1 || g_data !== '0) begin
      errors++;
      $display("FAIL flush_lookup: got hit=%0b probes=%0d data=%0h exp hit=0 probes=1 data=0", g_hit, g_probes, g_data);
    end
    // flush wins over a same-cycle request
    @(negedge clk);
    req_op = 1; req_key = 32'h9; req_data = 32'h9; req_valid = 1; flush = 1;
    @(posedge clk); #1;
    req_valid = 0; flush = 0;
    model_clear();
    seen = 0;
    repeat (4) begin @(posedge clk); #1; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) seen = 1; end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL flush_priority: got valid=%0b ready=%0b exp valid=0 ready=1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_random();
    logic [31:0] pool[6];
    bit op;
    logic [31:0] k, d;
    for (int i = 0; i < 6; i++) pool[i] = $urandom;
    pool[5] = pool[0] ^ 32'h00010001;  // same hash as pool[0], distinct key
    do_flush();
    for (int n = 0; n < 80; n++) begin
      op = 1'($urandom_range(0, 1));
      k  = pool[$urandom_range(0, 5)];
      d  = $urandom;
      send_req(op, k, d);
      wait_rsp();
      take_rsp($urandom_range(0, 2));
      model_op(op, k, d);
      checks++;
      if (g_to || g_hit !== e_hit || g_full !== e_full || g_data !== e_data || g_probes !== e_probes ||
          g_lat !== int'(e_probes) + 1) begin
        errors++;
        $display("FAIL rand[%0d] op=%0b key=%0h: got hit=%0b full=%0b data=%0h probes=%0d lat=%0d exp hit=%0b full=%0b data=%0h probes=%0d",
                 n, op, k, g_hit, g_full, g_data, g_probes, g_lat, e_hit, e_full, e_data, e_probes);
      end
    end
`ifdef HASH_PROBE_STATS_EN
    checks++;
    if (stat_hits !== 16'(m_hits) || stat_misses !== 16'(m_miss)) begin
      errors++;
      $display("FAIL rand_stats: got hits=%0d misses=%0d exp %0d %0d", stat_hits, stat_misses, m_hits, m_miss);
    end
`endif
  endtask

  task automatic test_reset_mid();
    send_req(1, 32'h00030006, 32'h3);
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_probes !== '0) begin
      errors++;
      $display("FAIL reset_mid: got ready=%0b valid=%0b probes=%0d exp 1 0 0", req_ready, rsp_valid, rsp_probes);
    end
    @(negedge clk);
    rst_n = 1;
    model_clear();
    send_req(0, 32'h00030006, 0); wait_rsp(); take_rsp(0); model_op(0, 32'h00030006, 0);
    checks++;
    if (g_to || g_hit !== 1'b0 || g_probes !== 1) begin
      errors++;
      $display("FAIL reset_mid_lookup: got hit=%0b probes=%0d exp hit=0 probes=1", g_hit, g_probes);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
